// File: rtl/water_dispenser_multi.sv
// Multi-channel water dispenser controller: digit entry via one-hot switches,
// then a prescaled countdown with one valve open; cancel clears or aborts.
module water_dispenser_multi #(
  parameter int SWITCH_COUNT   = 10,
  parameter int MAX_DIGITS     = 4,
  parameter int TIME_WIDTH     = 14,
  parameter int CHANNELS       = 4,
  parameter int CH_WIDTH       = 2,
  parameter int TICKS_PER_UNIT = 1000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [SWITCH_COUNT-1:0]               switches,
  input  logic [CH_WIDTH-1:0]                   channel,
  input  logic                                  button_add,
  input  logic                                  button_ok,
  input  logic                                  button_cancel,
  output logic [TIME_WIDTH-1:0]                 total_time,
  output logic [CHANNELS-1:0]                   valves,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [$clog2(MAX_DIGITS+1)-1:0]       digit_count
);

  localparam int DC_W  = $clog2(MAX_DIGITS + 1);
  localparam int PS_W  = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int SC_W  = $clog2(SWITCH_COUNT + 1);
  localparam logic [DC_W-1:0]       MAX_DC    = DC_W'(MAX_DIGITS);
  localparam logic [PS_W-1:0]       TICK_LAST = PS_W'(TICKS_PER_UNIT - 1);
  localparam logic [TIME_WIDTH-1:0] RADIX     = TIME_WIDTH'(SWITCH_COUNT);

  typedef enum logic {IDLE, DISPENSE} state_t;

  state_t                state;
  logic [PS_W-1:0]       prescaler;
  logic                  add_q, ok_q, cancel_q;
  logic                  add_ev, ok_ev, cancel_ev;
  logic [SC_W-1:0]       sw_count;
  logic [TIME_WIDTH-1:0] sw_index;
  logic                  channel_ok;

  assign add_ev     = button_add    & ~add_q;
  assign ok_ev      = button_ok     & ~ok_q;
  assign cancel_ev  = button_cancel & ~cancel_q;
  assign channel_ok = (32'(channel) < CHANNELS);

  // Count set switches and remember the index of the (last) set one.
  always_comb begin
    sw_count = '0;
    sw_index = '0;
    for (int i = 0; i < SWITCH_COUNT; i++) begin
      if (switches[i]) begin
        sw_count = sw_count + 1'b1;
        sw_index = TIME_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      total_time  <= '0;
      valves      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      digit_count <= '0;
      prescaler   <= '0;
      add_q       <= 1'b0;
      ok_q        <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      add_q    <= button_add;
      ok_q     <= button_ok;
      cancel_q <= button_cancel;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel_ev) begin
            total_time  <= '0;
            digit_count <= '0;
          end else if (ok_ev) begin
            if (total_time != '0 && channel_ok) begin
              valves      <= CHANNELS'(1) << channel;
              busy        <= 1'b1;
              prescaler   <= '0;
              digit_count <= '0;
              state       <= DISPENSE;
            end else begin
              error <= 1'b1;
            end
          end else if (add_ev && digit_count < MAX_DC) begin
            // A full entry silently ignores further digits; otherwise demand one-hot.
            if (sw_count == SC_W'(1)) begin
              total_time  <= total_time * RADIX + sw_index;
              digit_count <= digit_count + 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          if (cancel_ev) begin
            valves     <= '0;
            busy       <= 1'b0;
            total_time <= '0;
            state      <= IDLE;
          end else if (prescaler == TICK_LAST) begin
            prescaler <= '0;
            if (total_time <= TIME_WIDTH'(1)) begin
              total_time <= '0;
              valves     <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              total_time <= total_time - 1'b1;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_water_dispenser_multi.sv
// Directed bench for water_dispenser_multi with a short prescaler and a
// 3-bit channel select so out-of-range channels can be driven.
module tb_water_dispenser_multi;

  localparam int SWITCH_COUNT   = 10;
  localparam int MAX_DIGITS     = 4;
  localparam int TIME_WIDTH     = 14;
  localparam int CHANNELS       = 4;
  localparam int CH_WIDTH       = 3;
  localparam int TICKS_PER_UNIT = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [SWITCH_COUNT-1:0] switches;
  logic [CH_WIDTH-1:0]     channel;
  logic                    button_add, button_ok, button_cancel;
  logic [TIME_WIDTH-1:0]   total_time;
  logic [CHANNELS-1:0]     valves;
  logic                    busy, done, error;
  logic [2:0]              digit_count;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  water_dispenser_multi #(
    .SWITCH_COUNT(SWITCH_COUNT), .MAX_DIGITS(MAX_DIGITS), .TIME_WIDTH(TIME_WIDTH),
    .CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH), .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) dut (
    .clock(clock), .reset(reset), .switches(switches), .channel(channel),
    .button_add(button_add), .button_ok(button_ok), .button_cancel(button_cancel),
    .total_time(total_time), .valves(valves), .busy(busy), .done(done),
    .error(error), .digit_count(digit_count)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  always @(negedge clock) if (done) done_cnt++;

  // Driver tasks: advance to just after the next rising edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_add(input logic [SWITCH_COUNT-1:0] sw, output logic err);
    switches = sw;
    button_add = 1'b1;
    cyc();
    err = error;
    button_add = 1'b0;
    cyc();
  endtask

  task automatic press_ok(output logic err);
    button_ok = 1'b1;
    cyc();
    err = error;
    button_ok = 1'b0;
    cyc();
  endtask

  task automatic press_cancel();
    button_cancel = 1'b1;
    cyc();
    button_cancel = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; switches = '0; channel = '0;
    button_add = 1'b0; button_ok = 1'b0; button_cancel = 1'b0;
    cyc(2);
    reset = 1'b0;
    checks++;
    if ({total_time, valves, busy, done, error, digit_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got time=%0d valves=%b busy=%b done=%b err=%b dc=%0d want all 0",
               total_time, valves, busy, done, error, digit_count);
    end
  endtask

  task automatic test_entry();
    logic err;
    press_add(10'b1 << 1, err);
    press_add(10'b1 << 9, err);
    press_add(10'b1 << 9, err);
    press_add(10'b1 << 3, err);
    checks++;
    if (total_time !== 14'd1993 || digit_count !== 3'd4) begin
      failures++;
      $display("FAIL entry_1993 got time=%0d dc=%0d want 1993/4", total_time, digit_count);
    end
    press_add(10'b1 << 5, err);
    checks++;
    if (total_time !== 14'd1993 || err !== 1'b0) begin
      failures++;
      $display("FAIL entry_full got time=%0d err=%b want 1993/0", total_time, err);
    end
  endtask

  task automatic test_countdown();
    logic err;
    press_cancel();
    press_add(10'b1 << 3, err);
    channel = 3'd2;
    button_ok = 1'b1;
    cyc();
    button_ok = 1'b0;
    checks++;
    if (valves !== 4'b0100 || busy !== 1'b1 || total_time !== 14'd3) begin
      failures++;
      $display("FAIL cd_start got valves=%b busy=%b time=%0d want 0100/1/3", valves, busy, total_time);
    end
    cyc(3);
    checks++;
    if (total_time !== 14'd3) begin
      failures++;
      $display("FAIL cd_edge3 got %0d want 3", total_time);
    end
    cyc();
    checks++;
    if (total_time !== 14'd2) begin
      failures++;
      $display("FAIL cd_edge4 got %0d want 2", total_time);
    end
    cyc(4);
    checks++;
    if (total_time !== 14'd1) begin
      failures++;
      $display("FAIL cd_edge8 got %0d want 1", total_time);
    end
    cyc(3);
    checks++;
    if (busy !== 1'b1 || total_time !== 14'd1 || done !== 1'b0) begin
      failures++;
      $display("FAIL cd_edge11 got busy=%b time=%0d done=%b want 1/1/0", busy, total_time, done);
    end
    cyc();
    checks++;
    if (total_time !== 14'd0 || done !== 1'b1 || valves !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cd_edge12 got time=%0d done=%b valves=%b busy=%b want 0/1/0000/0",
               total_time, done, valves, busy);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL cd_done_once got done=%b count=%0d want 0/1", done, done_cnt);
    end
  endtask

  task automatic test_cancel();
    logic err;
    press_add(10'b1 << 7, err);
    channel = 3'd0;
    button_ok = 1'b1;
    cyc();
    button_ok = 1'b0;
    cyc(4);
    button_cancel = 1'b1;
    cyc();
    button_cancel = 1'b0;
    checks++;
    if (valves !== 4'b0000 || busy !== 1'b0 || total_time !== 14'd0) begin
      failures++;
      $display("FAIL cancel_abort got valves=%b busy=%b time=%0d want 0000/0/0", valves, busy, total_time);
    end
    cyc(8);
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL cancel_no_done got count=%0d want 1", done_cnt);
    end
    press_ok(err);
    checks++;
    if (err !== 1'b1 || valves !== 4'b0000) begin
      failures++;
      $display("FAIL ok_zero_time got err=%b valves=%b want 1/0000", err, valves);
    end
  endtask

  task automatic test_errors();
    logic err;
    press_add(10'b1 << 2, err);
    press_add(10'b0, err);
    checks++;
    if (err !== 1'b1 || total_time !== 14'd2) begin
      failures++;
      $display("FAIL add_none got err=%b time=%0d want 1/2", err, total_time);
    end
    press_add(10'b0000010100, err);
    checks++;
    if (err !== 1'b1 || total_time !== 14'd2 || digit_count !== 3'd1) begin
      failures++;
      $display("FAIL add_multi got err=%b time=%0d dc=%0d want 1/2/1", err, total_time, digit_count);
    end
    channel = 3'd5;
    press_ok(err);
    checks++;
    if (err !== 1'b1 || valves !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ok_bad_channel got err=%b valves=%b busy=%b want 1/0000/0", err, valves, busy);
    end
  endtask

  task automatic test_priority();
    logic err;
    channel = 3'd1;
    button_ok = 1'b1;
    button_cancel = 1'b1;
    cyc();
    button_ok = 1'b0;
    button_cancel = 1'b0;
    checks++;
    if (total_time !== 14'd0 || busy !== 1'b0 || valves !== 4'b0000 || error !== 1'b0) begin
      failures++;
      $display("FAIL cancel_over_ok got time=%0d busy=%b valves=%b err=%b want 0/0/0000/0",
               total_time, busy, valves, error);
    end
    cyc();
    press_add(10'b1 << 4, err);
    switches = 10'b1 << 7;
    button_add = 1'b1;
    button_ok = 1'b1;
    cyc();
    button_add = 1'b0;
    button_ok = 1'b0;
    checks++;
    if (busy !== 1'b1 || valves !== 4'b0010 || total_time !== 14'd4 || digit_count !== 3'd0) begin
      failures++;
      $display("FAIL ok_over_add got busy=%b valves=%b time=%0d dc=%0d want 1/0010/4/0",
               busy, valves, total_time, digit_count);
    end
    cyc();
    press_cancel();
  endtask

  task automatic test_back_to_back();
    logic err;
    switches = 10'b1 << 6;
    button_add = 1'b1;
    cyc(10);
    button_add = 1'b0;
    cyc();
    checks++;
    if (total_time !== 14'd6 || digit_count !== 3'd1) begin
      failures++;
      $display("FAIL held_add got time=%0d dc=%0d want 6/1", total_time, digit_count);
    end
    channel = 3'd3;
    press_ok(err);
    cyc(2);
    checks++;
    if (valves !== 4'b1000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_dispense got valves=%b busy=%b want 1000/1", valves, busy);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({total_time, valves, busy, done, error, digit_count} !== '0) begin
      failures++;
      $display("FAIL mid_reset got time=%0d valves=%b busy=%b done=%b err=%b dc=%0d want all 0",
               total_time, valves, busy, done, error, digit_count);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_countdown();
    test_cancel();
    test_errors();
    test_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/water_dispenser_multi.md
Name: water_dispenser_multi

Overview:
Parametrised multi-channel successor to the single-outlet dispenser controller. The user keys a dispense time digit by digit using one-hot switches and an add button. OK opens the valve of a selected channel and counts the time down at a prescaled rate; cancel aborts. It sits between the debounced front-panel inputs and the valve drivers, and exposes the time for the display.

Parameters:
SWITCH_COUNT, 10, number of one-hot digit switches; also the digit radix (digit value = switch index).
MAX_DIGITS, 4, maximum digits accepted per entry.
TIME_WIDTH, 14, width of total_time; must hold SWITCH_COUNT^MAX_DIGITS-1.
CHANNELS, 4, number of valves.
CH_WIDTH, 2, width of channel select; must be at least clog2(CHANNELS), minimum 1.
TICKS_PER_UNIT, 1000, clock cycles per time unit during countdown; must be at least 1.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
switches  input  SWITCH_COUNT  one-hot digit select.
channel  input  CH_WIDTH  valve to open; sampled only on an accepted OK.
button_add  input  1  append the selected digit (level input, edge-detected internally).
button_ok  input  1  start dispensing (edge-detected internally).
button_cancel  input  1  clear the entry or abort dispensing (edge-detected internally).
total_time  output  TIME_WIDTH  entry value in IDLE; remaining units in DISPENSE.
valves  output  CHANNELS  one-hot open valve, or all zero.
busy  output  1  high while in DISPENSE.
done  output  1  one-cycle pulse when a countdown reaches 0.
error  output  1  one-cycle pulse on a rejected action.
digit_count  output  clog2(MAX_DIGITS+1)  digits entered so far.

Behaviour:
- Reset (synchronous, active-high): total_time=0, valves=0, busy=0, done=0, error=0, digit_count=0, prescaler=0, button history=0, state=IDLE.
- Reset asserted mid-dispense closes the valves at that same edge.
- Edge detect: each button has a registered copy. An event fires at the edge where button=1 and its registered copy=0. Registered outputs reflect the event after that edge. A held button fires exactly once.
- Priority when events coincide: cancel > ok > add. Only the highest-priority event is acted on.
- done and error default to 0 each cycle unless set as described below.
- States: IDLE, DISPENSE.

IDLE:
- Add with exactly one switch set and digit_count<MAX_DIGITS: total_time <= total_time*SWITCH_COUNT + index; digit_count++.
- Add with zero or several switches set: no change; error pulse.
- Add with digit_count==MAX_DIGITS: ignored, no error.
- OK with total_time>0 and channel<CHANNELS: latch the channel; valves <= 1<<channel; busy=1; prescaler=0; go to DISPENSE. digit_count <= 0.
- OK with total_time==0 or channel>=CHANNELS: stay in IDLE; error pulse.
- Cancel: total_time=0, digit_count=0.

DISPENSE:
- Prescaler counts 0..TICKS_PER_UNIT-1 and wraps. At each wrap, total_time decrements, so the first decrement occurs TICKS_PER_UNIT edges after the start.
- Decrement from 1 to 0: at that edge valves=0, busy=0, done=1 (one cycle), state=IDLE.
- Cancel: valves=0, busy=0, total_time=0, go to IDLE, no done pulse.
- Add and OK are ignored, with no error. Changes on switches or channel have no effect.
- total_time never underflows.
- Invariants: valves is never multi-hot, and valves≠0 if and only if busy.

Test Plan:
1. Reset, then add digits 1,9,9,3 (one switch per add) -> total_time=1993, digit_count=4. A fifth add of 5 -> still 1993, no error.
2. TICKS_PER_UNIT=4, entry 3, channel=2, OK -> valves=4'b0100, busy=1. total_time becomes 2/1/0 at 4/8/12 edges after start; at 0, done pulses once, valves=0, busy=0.
3. Entry 7, OK, cancel 5 edges later -> valves=0, total_time=0, no done pulse. A subsequent OK -> error pulse.
4. Add with switches=0 and with switches[2]=switches[4]=1 -> error pulses, total_time unchanged. OK with channel=5 when CHANNELS=4 -> error pulse, valves=0.
5. Entry 2; OK and cancel rise on the same edge -> cancel wins: IDLE, total_time=0. Add and OK on the same edge with entry 4 -> dispense starts and the digit is dropped.
6. Holding button_add high for 10 cycles with switches[6]=1 -> exactly one digit appended. Reset asserted mid-dispense -> all outputs 0 after that edge.
